// File: rtl/mem_access_unit_pkg.sv
// Shared types and sizing helpers for the MAR/MDR memory-access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W = $clog2(TIMEOUT_DEFAULT + 1);

    // Counter width able to hold values up to the given timeout.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bundle between the access unit and the RAM chip.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] MAR_to_chip;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output MAR_to_chip, mem_req, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  MAR_to_chip, mem_req, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit_timer.sv
// Counts request cycles so the unit can give up on a RAM that never acks.
module mem_wait_timer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int W       = CNT_W
) (
    input  logic clear,
    input  logic clock,
    input  logic start,
    input  logic run,
    output logic expired
);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT - 1));

    // Restart from zero on a new request, otherwise advance while waiting.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR holding registers plus the req/ack sequencer towards a
// variable-latency RAM; reports busy/done/timeout to the control unit.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  Mem_read,
    input  logic                  Mem_write,
    output logic [DATA_WIDTH-1:0] MDR_BusMuxIn,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    mem_access_unit_if.master     mem
);

    localparam int TW = cnt_width(TIMEOUT);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr;
    logic                  req_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  in_req;
    logic                  start;
    logic                  start_we;
    logic                  can_load;
    logic                  expired;
    logic                  ack_exit;
    logic                  time_exit;

    // Read has priority when both strobes arrive together.
    assign in_req    = (state == REQ);
    assign start     = (state == IDLE) && (Mem_read || Mem_write);
    assign start_we  = Mem_write && !Mem_read;
    assign can_load  = !in_req;
    assign ack_exit  = in_req && mem.mem_ack;
    assign time_exit = in_req && !mem.mem_ack && expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (TW)
    ) u_timer (
        .clear   (clear),
        .clock   (clock),
        .start   (start),
        .run     (in_req),
        .expired (expired)
    );

    // Next-state decision for the request sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = REQ;
            REQ:     if (ack_exit || time_exit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    // MAR follows the bus except while a request holds the address stable.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mar <= '0;
        end else if (can_load && MARin) begin
            mar <= BusMuxOut[ADDR_WIDTH-1:0];
        end
    end

    // MDR takes read data on ack, otherwise bus loads outside of a request.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mdr <= '0;
        end else if (ack_exit && !we_q) begin
            mdr <= mem.mem_rdata;
        end else if (can_load && MDRin) begin
            mdr <= BusMuxOut;
        end
    end

    // Registered handshake and status outputs derived from the next state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            req_q  <= (next_state == REQ);
            busy_q <= (next_state == REQ);
            done_q <= in_req && (next_state == DONE);
            if (start) begin
                we_q  <= start_we;
                err_q <= 1'b0;
            end else if (time_exit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem.MAR_to_chip = mar;
    assign mem.mem_req     = req_q;
    assign mem.mem_we      = we_q;
    assign mem.mem_wdata   = mdr;
    assign MDR_BusMuxIn    = mdr;
    assign busy            = busy_q;
    assign done            = done_q;
    assign timeout_err     = err_q;

endmodule
